// File: rtl/dmem_arb.sv
// ============================================================================
//  Module   : dmem_arb
//  Purpose  : Shared external-memory port controller. Arbitrates line
//             refill/writeback bursts between the I-cache and D-cache miss
//             handlers, sequences command / data beats / completion, and
//             routes beat data to and from the owning requester.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // I side
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_rvalid,
  output logic [DATA_W-1:0]             i_rdata,
  output logic                          i_done,
  // D side
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [$clog2(BURST_LEN)-1:0]  d_wbeat,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_done,
  // memory port
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_cmd_ack,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_wready,
  output logic [DATA_W-1:0]             mem_wdata
);

  localparam int                c_cnt_w     = $clog2(BURST_LEN);
  localparam int                c_off_w     = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [ADDR_W-1:0] c_addr_mask = {ADDR_W{1'b1}} << c_off_w;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  // owner: 0 = I, 1 = D. Only meaningful outside IDLE, which is how
  // "no owner" is represented.
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;   // 1 = D
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Set for the single IDLE cycle following a done pulse to that side, so a
  // requester that drops req one cycle late is not granted a phantom burst.
  logic                mask_i_q, mask_i_d;
  logic                mask_d_q, mask_d_d;

  logic                w_req_i;
  logic                w_req_d;
  logic                w_grant_d;
  logic                w_beat;

  // State register; reset abandons any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      mask_i_q     <= mask_i_d;
      mask_d_q     <= mask_d_d;
    end
  end

  // Next-state, arbitration and output routing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    mask_i_d     = 1'b0;
    mask_d_d     = 1'b0;

    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_done    = 1'b0;
    d_wbeat   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    w_req_i   = i_req & ~mask_i_q;
    w_req_d   = d_req & ~mask_d_q;
    // Tie goes to the side that did not win last; otherwise the lone requester.
    w_grant_d = (w_req_i && w_req_d) ? ~last_grant_q : w_req_d;
    w_beat    = we_q ? mem_wready : mem_rvalid;

    unique case (state_q)
      S_IDLE: begin
        if (w_req_i || w_req_d) begin
          state_d      = S_CMD;
          owner_d      = w_grant_d;
          last_grant_d = w_grant_d;
          we_d         = w_grant_d & d_we;
          addr_d       = (w_grant_d ? d_addr : i_addr) & c_addr_mask;
        end
      end

      S_CMD: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = addr_q;
        if (mem_cmd_ack) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end
      end

      S_XFER: begin
        mem_we   = we_q;
        mem_addr = addr_q;
        if (we_q) begin
          d_wbeat   = cnt_q;
          mem_wdata = d_wdata;
        end else if (mem_rvalid) begin
          if (owner_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
        if (w_beat) begin
          cnt_d = cnt_q + c_cnt_w'(1);
          if (cnt_q == c_last_beat) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        i_done   = ~owner_q;
        d_done   = owner_q;
        mask_i_d = ~owner_q;
        mask_d_d = owner_q;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
